// File: rtl/core_pkg.sv
// Shared RV32 core types: result-select and memory-size encodings, MEM/WB record.
// Latency: none (types and constants only).
// Backpressure: none.
// Fields:
//   mem_wb_t holds everything writeback needs from the memory stage.
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_t;

  typedef enum logic [2:0] {
    SZ_BYTE = 3'b000,
    SZ_HALF = 3'b001,
    SZ_WORD = 3'b010
  } mem_size_t;

  // The size is kept as raw bits so that the undefined codes survive the
  // register and fall into the word path of the extractor.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    result_src_t       result_src;
    logic [4:0]        rd;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   read_data;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm_ext;
    logic [2:0]        mem_size;
    logic              load_sext;
  } mem_wb_t;

endpackage

// File: rtl/load_extend.sv
// Load data extractor: selects the byte/half lane from an aligned word and extends it.
// Latency: purely combinational.
// Backpressure: none.
// Ports:
//   word in (aligned memory word), offset in (address bits [1:0]),
//   size in (byte/half/word, other codes = word), sext in (1 = sign-extend), data out.
module load_extend
  import core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       offset,
  input  logic [2:0]       size,
  input  logic             sext,
  output logic [WIDTH-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[7:0];
    case (offset)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
  end

  // offset[0] is ignored for halves: misaligned halves trap before reaching here.
  assign half_lane = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (size)
      SZ_BYTE: data = {{(WIDTH-8){sext & byte_lane[7]}}, byte_lane};
      SZ_HALF: data = {{(WIDTH-16){sext & half_lane[15]}}, half_lane};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, load extraction, result mux, x0 gating, instret counter.
// Latency: one cycle from *_M inputs to W outputs; everything after the register is combinational.
// Backpressure: en_W=0 holds the register (and its write) stable; flush_W loads a bubble and wins over the stall.
// Ports:
//   clk/rst (sync, active-high), en_W/flush_W pipeline control, *_M memory-stage fields in,
//   regWrite_W/Rd_W/result_W register-file write port out, valid_W slot status, instret retire count.
module writeback_stage
  import core_pkg::*;
#(
  parameter int WIDTH = 32,  // only 32 is supported
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_W,
  input  logic             flush_W,
  input  logic             valid_M,
  input  logic             regWrite_M,
  input  logic [1:0]       resultSrc_M,
  input  logic [4:0]       Rd_M,
  input  logic [WIDTH-1:0] ALUResult_M,
  input  logic [WIDTH-1:0] ReadData_M,
  input  logic [WIDTH-1:0] PCPlus4_M,
  input  logic [WIDTH-1:0] ImmExt_M,
  input  logic [2:0]       DMem_size_M,
  input  logic             load_extend_s_M,
  output logic             regWrite_W,
  output logic [4:0]       Rd_W,
  output logic [WIDTH-1:0] result_W,
  output logic             valid_W,
  output logic [CNT_W-1:0] instret
);

  mem_wb_t          mem_wb_q;
  mem_wb_t          mem_wb_d;
  logic [CNT_W-1:0] instret_q;
  logic [WIDTH-1:0] load_data;

  always_comb begin
    mem_wb_d            = '0;
    mem_wb_d.valid      = valid_M;
    mem_wb_d.reg_write  = regWrite_M;
    mem_wb_d.result_src = result_src_t'(resultSrc_M);
    mem_wb_d.rd         = Rd_M;
    mem_wb_d.alu_result = ALUResult_M;
    mem_wb_d.read_data  = ReadData_M;
    mem_wb_d.pc_plus4   = PCPlus4_M;
    mem_wb_d.imm_ext    = ImmExt_M;
    mem_wb_d.mem_size   = DMem_size_M;
    mem_wb_d.load_sext  = load_extend_s_M;
  end

  // Counting at capture time means a stalled instruction is counted once,
  // and a flushed one never.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb_q  <= '0;
      instret_q <= '0;
    end else if (flush_W) begin
      mem_wb_q  <= '0;
    end else if (en_W) begin
      mem_wb_q  <= mem_wb_d;
      if (valid_M) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  load_extend #(
    .WIDTH (WIDTH)
  ) u_load_extend (
    .word   (mem_wb_q.read_data),
    .offset (mem_wb_q.alu_result[1:0]),
    .size   (mem_wb_q.mem_size),
    .sext   (mem_wb_q.load_sext),
    .data   (load_data)
  );

  always_comb begin
    result_W = mem_wb_q.alu_result;
    case (mem_wb_q.result_src)
      RES_ALU:  result_W = mem_wb_q.alu_result;
      RES_LOAD: result_W = load_data;
      RES_PC4:  result_W = mem_wb_q.pc_plus4;
      RES_IMM:  result_W = mem_wb_q.imm_ext;
      default:  result_W = mem_wb_q.alu_result;
    endcase
  end

  // x0 is hardwired to zero, so a write to it is never presented.
  assign regWrite_W = mem_wb_q.reg_write & mem_wb_q.valid & (mem_wb_q.rd != 5'd0);
  assign Rd_W       = mem_wb_q.rd;
  assign valid_W    = mem_wb_q.valid;
  assign instret    = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vectors followed by random traffic,
// expected outputs produced by a reference model and compared by a monitor.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, en_W, flush_W, valid_M, regWrite_M, load_extend_s_M;
  logic [1:0]  resultSrc_M;
  logic [4:0]  Rd_M;
  logic [31:0] ALUResult_M, ReadData_M, PCPlus4_M, ImmExt_M;
  logic [2:0]  DMem_size_M;
  logic        regWrite_W, valid_W;
  logic [4:0]  Rd_W;
  logic [31:0] result_W;
  logic [63:0] instret;

  writeback_stage #(.WIDTH(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .en_W(en_W), .flush_W(flush_W), .valid_M(valid_M),
    .regWrite_M(regWrite_M), .resultSrc_M(resultSrc_M), .Rd_M(Rd_M),
    .ALUResult_M(ALUResult_M), .ReadData_M(ReadData_M), .PCPlus4_M(PCPlus4_M),
    .ImmExt_M(ImmExt_M), .DMem_size_M(DMem_size_M), .load_extend_s_M(load_extend_s_M),
    .regWrite_W(regWrite_W), .Rd_W(Rd_W), .result_W(result_W), .valid_W(valid_W),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, en, flush, valid, rw;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [31:0] alu, rdata, pc4, imm;
    logic [2:0]  size;
    logic        sext;
  } stim_t;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        valid;
    logic [63:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  stim_t m_slot;          // instruction currently held by the model's WB slot
  logic [63:0] m_cnt;
  int checks = 0;
  int errors = 0;

  // Architectural meaning of an RV32 load: shift the addressed lane down,
  // mask to size, then extend.
  function automatic logic [31:0] load_value(logic [31:0] w, logic [1:0] off,
                                             logic [2:0] sz, logic s);
    logic [31:0] v;
    if (sz == 3'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (s && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 3'd1) begin
      v = (w >> (16 * off[1])) & 32'hFFFF;
      if (s && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic exp_t model_out(stim_t st, logic [63:0] cnt);
    exp_t e;
    e.valid = st.valid;
    e.rd    = st.rd;
    e.rw    = st.valid && st.rw && (st.rd != 0);
    case (st.src)
      2'd0: e.result = st.alu;
      2'd1: e.result = load_value(st.rdata, st.alu[1:0], st.size, st.sext);
      2'd2: e.result = st.pc4;
      default: e.result = st.imm;
    endcase
    e.cnt = cnt;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, advance the model to
  // what the next rising edge should produce, and queue that expectation.
  task automatic step(input stim_t s, input bit deposit_ones);
    @(negedge clk);
    if (deposit_ones) begin
      force dut.instret_q = '1;
      #1;
      release dut.instret_q;
      m_cnt = '1;
    end
    rst = s.rst; en_W = s.en; flush_W = s.flush; valid_M = s.valid;
    regWrite_M = s.rw; resultSrc_M = s.src; Rd_M = s.rd; ALUResult_M = s.alu;
    ReadData_M = s.rdata; PCPlus4_M = s.pc4; ImmExt_M = s.imm;
    DMem_size_M = s.size; load_extend_s_M = s.sext;
    if (s.rst) begin
      m_slot = '0;
      m_cnt  = '0;
    end else if (s.flush) begin
      m_slot = '0;
    end else if (s.en) begin
      m_slot = s;
      if (s.valid) m_cnt = m_cnt + 1;
    end
    exp_q.push_back(model_out(m_slot, m_cnt));
  endtask

  function automatic stim_t instr(logic [1:0] src, logic [4:0] rd, logic [31:0] alu,
                                  logic [31:0] rdata, logic [2:0] size, logic sext);
    stim_t s = '0;
    s.en = 1'b1; s.valid = 1'b1; s.rw = 1'b1;
    s.src = src; s.rd = rd; s.alu = alu; s.rdata = rdata;
    s.pc4 = 32'h0000_0108; s.imm = 32'hABCD_E000; s.size = size; s.sext = sext;
    return s;
  endfunction

  // Monitor: after every rising edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("regWrite_W", 64'(regWrite_W), 64'(e.rw));
        chk("Rd_W",       64'(Rd_W),       64'(e.rd));
        chk("result_W",   64'(result_W),   64'(e.result));
        chk("valid_W",    64'(valid_W),    64'(e.valid));
        chk("instret",    instret,         e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    m_slot = '0; m_cnt = '0;
    rst = 1'b1; en_W = 1'b0; flush_W = 1'b0; valid_M = 1'b0; regWrite_M = 1'b0;
    resultSrc_M = '0; Rd_M = '0; ALUResult_M = '0; ReadData_M = '0;
    PCPlus4_M = '0; ImmExt_M = '0; DMem_size_M = '0; load_extend_s_M = 1'b0;

    // Reset for two cycles, then idle.
    s = '0; s.rst = 1'b1;
    step(s, 0); step(s, 0);
    s = '0; s.en = 1'b1;
    step(s, 0); step(s, 0);

    // Byte loads, signed then unsigned, from lane 3.
    step(instr(2'd1, 5'd5, 32'h1003, 32'h80FF_7F01, 3'd0, 1'b1), 0);
    step(instr(2'd1, 5'd5, 32'h1003, 32'h80FF_7F01, 3'd0, 1'b0), 0);
    // Half loads and a word load at offset 3.
    step(instr(2'd1, 5'd6, 32'h2002, 32'h8001_1234, 3'd1, 1'b1), 0);
    step(instr(2'd1, 5'd6, 32'h2000, 32'h8001_1234, 3'd1, 1'b1), 0);
    step(instr(2'd1, 5'd6, 32'h2003, 32'h8001_1234, 3'd2, 1'b1), 0);
    // PC+4, immediate, and a write to x0.
    step(instr(2'd2, 5'd1, 32'h0, 32'h0, 3'd2, 1'b0), 0);
    step(instr(2'd3, 5'd2, 32'h0, 32'h0, 3'd2, 1'b0), 0);
    step(instr(2'd0, 5'd0, 32'h1234_5678, 32'h0, 3'd2, 1'b0), 0);

    // Capture, then stall three cycles while a new valid instruction waits.
    step(instr(2'd0, 5'd9, 32'hCAFE_0001, 32'h0, 3'd2, 1'b0), 0);
    s = instr(2'd0, 5'd10, 32'h5555_AAAA, 32'h0, 3'd2, 1'b0); s.en = 1'b0;
    step(s, 0); step(s, 0); step(s, 0);
    // Flush during a stall, then flush over a valid capture.
    s.flush = 1'b1;
    step(s, 0);
    s.en = 1'b1;
    step(s, 0);
    // Reset while an instruction is held.
    step(instr(2'd0, 5'd11, 32'h7777_0000, 32'h0, 3'd2, 1'b0), 0);
    s = '0; s.en = 1'b0; step(s, 0);
    s.rst = 1'b1; step(s, 0);
    s = '0; s.en = 1'b0; step(s, 0);

    // Counter wrap from all-ones.
    step(instr(2'd0, 5'd3, 32'h0000_0042, 32'h0, 3'd2, 1'b0), 1);
    step(instr(2'd0, 5'd3, 32'h0000_0043, 32'h0, 3'd2, 1'b0), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(0, 39) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.en    = ($urandom_range(0, 3) != 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.rw    = ($urandom_range(0, 4) != 0);
      s.src   = 2'($urandom_range(0, 3));
      s.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s.alu   = $urandom; s.rdata = $urandom; s.pc4 = $urandom; s.imm = $urandom;
      s.size  = 3'($urandom_range(0, 7));
      s.sext  = 1'($urandom_range(0, 1));
      step(s, 0);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the RV32 core. It holds the MEM/WB pipeline register, extracts and extends load data, and selects the writeback result.
- It is the register-file writer: it drives regWrite_W, Rd_W and result_W, which decode consumes through the register write port (WE3/rd/WD3).
- It also keeps a retired-instruction counter for performance and debug.

Parameters:
- WIDTH, 32, datapath width; this block supports only 32.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en_W  in  1  MEM/WB register load enable (0 = stall, hold contents)
- flush_W  in  1  load a bubble into MEM/WB
- valid_M  in  1  memory-stage slot holds a real instruction
- regWrite_M  in  1  instruction writes rd
- resultSrc_M  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate (lui)
- Rd_M  in  5  destination register
- ALUResult_M  in  WIDTH  ALU result; also the load address, bits [1:0] = byte offset
- ReadData_M  in  WIDTH  raw aligned data-memory word
- PCPlus4_M  in  WIDTH  link value
- ImmExt_M  in  WIDTH  extended immediate
- DMem_size_M  in  3  000 byte, 001 half, 010 word; other codes treated as word
- load_extend_s_M  in  1  1 = sign-extend, 0 = zero-extend
- regWrite_W  out  1  register-file write enable
- Rd_W  out  5  register-file write address
- result_W  out  WIDTH  register-file write data
- valid_W  out  1  WB slot holds a real instruction
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=1 at a clk edge) clears every MEM/WB field and instret to 0. regWrite_W, Rd_W, result_W and valid_W then read 0.
- MEM/WB register update, evaluated at each rising edge:
  - rst: clear everything.
  - flush_W=1: load a bubble (all fields 0). Flush wins over stall.
  - en_W=1: capture every *_M input.
  - en_W=0: hold the current contents.
- Latency is one cycle from the *_M inputs to the W outputs. Everything downstream of the register is combinational.
- regWrite_W = regWrite_reg & valid_reg & (Rd_reg != 0). A write to x0 is never asserted.
- Load extraction, using off = ALUResult_reg[1:0]:
  - byte: take byte lane off.
  - half: take lane off[1] (bytes 1:0 or 3:2); off[0] is ignored, since misalignment is trapped upstream.
  - word: take the full word and ignore off.
  - byte and half are then sign-extended if load_extend_s_reg=1, else zero-extended.
- result_W mux on resultSrc_reg: ALU result, extracted load, PC+4, or ImmExt.
- instret increments by 1 at the same edge where the register captures valid_M=1 with en_W=1, flush_W=0 and rst=0.
  - It wraps from all-ones to 0.
  - A stalled instruction is counted exactly once.
- Simultaneous events:
  - rst beats flush_W, and flush_W beats en_W.
  - Reset mid-stall discards the held instruction; no write occurs afterwards.
- A held (stalled) instruction keeps regWrite_W asserted with a stable result_W. Repeating the same register-file write is benign.

Decomposition:
- Shared package core_pkg:
  - result_src_t enum (RES_ALU, RES_LOAD, RES_PC4, RES_IMM)
  - mem_size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - a packed struct mem_wb_t grouping the MEM/WB fields
- One combinational sub-module, load_extend: inputs are the word, offset, size and signed flag; output is WIDTH data. It is reused by any future store/load unit tests.
- The pipeline register, mux, x0 gating and counter stay in writeback_stage.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles. Require all outputs = 0 and instret = 0; after rst=0 with valid_M=0, outputs stay 0.
- Signed byte load: ReadData_M=0x80FF_7F01, ALUResult_M=0x1003, DMem_size_M=byte, load_extend_s_M=1, resultSrc_M=01, Rd_M=5. Next cycle require result_W=0xFFFF_FF80, Rd_W=5, regWrite_W=1, instret=1. Repeat with sign=0 and require 0x0000_0080.
- Half loads:
  - off=2, signed, ReadData_M=0x8001_1234: require 0xFFFF_8001.
  - off=0 on the same word: require 0x0000_1234.
  - Word load at off=3: require 0x8001_1234.
- Mux and x0 gating:
  - resultSrc 10 with PCPlus4_M=0x0000_0108: require result_W=0x108.
  - resultSrc 11 with ImmExt_M=0xABCDE000: require result_W=0xABCDE000.
  - Rd_M=0 with regWrite_M=1: require regWrite_W=0 while result_W still shows the ALU value.
- Stall/flush:
  - Capture an instruction, then hold en_W=0 for 3 cycles: require the outputs stable and instret to advance by only 1.
  - Assert flush_W=1 with en_W=0: next cycle require valid_W=0 and regWrite_W=0.
  - Assert flush_W=1 with valid_M=1: require instret unchanged.
- Counter wrap: force instret to all-ones (bench hierarchical deposit) and retire one valid instruction. Require instret=0.
